// File: rtl/dmem_responder.sv
// Single-port doubleword data memory with a valid/ready request/response handshake.
// Supports byte/half/word/double accesses and a configurable response latency.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | request accepted, counting down extra latency
  // RESP  | response presented until resp_ready

  localparam int          LAT      = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
  localparam logic [3:0]  CNT_LOAD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
  localparam logic [63:0] SPAN     = 64'd8 << DEPTH_LOG2;
  localparam int unsigned WORDS    = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  rdy_q;
  logic                  accept;
  logic [63:0]           mem [WORDS];
  logic [63:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic [2:0]            o;
  logic                  in_range;
  logic                  misaligned;
  logic                  err;
  logic [7:0]            bmask;
  logic [63:0]           wmask;
  logic [63:0]           lane;
  logic [63:0]           old_dw;
  logic [63:0]           new_dw;

  // Range test uses the offset so BASE + span can never wrap.
  always_comb begin
    offset     = req_addr - BASE;
    in_range   = (req_addr >= BASE) && (offset < SPAN);
    idx        = offset[DEPTH_LOG2+2:3];
    o          = req_addr[2:0];
    misaligned = 1'b0;
    bmask      = 8'h00;
    case (req_size)
      2'b00: bmask = 8'h01 << o;
      2'b01: begin
        misaligned = o[0];
        bmask      = 8'h03 << o;
      end
      2'b10: begin
        misaligned = (o[1:0] != 2'b00);
        bmask      = 8'h0F << o;
      end
      default: begin
        misaligned = (o != 3'b000);
        bmask      = 8'hFF;
      end
    endcase
    for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{bmask[b]}};
    lane   = req_wdata << {o, 3'b000};
    old_dw = mem[idx];
    new_dw = req_wr ? ((old_dw & ~wmask) | (lane & wmask)) : old_dw;
    err    = !in_range || misaligned;
  end

  assign req_ready  = rdy_q && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (LAT == 1) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else cnt_nxt = cnt - 4'd1;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rdy_q      <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy_q <= 1'b1;
      if (accept) begin
        resp_err   <= err;
        resp_rdata <= err ? 64'd0 : new_dw;
      end
    end
  end

  // Storage is never cleared; a store commits on its acceptance edge.
  always_ff @(posedge clock) begin
    if (reset && accept && req_wr && !err) mem[idx] <= new_dw;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=1 and one LATENCY=4 instance
// sharing request fields, checked against hand-computed values.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_ready;
  logic        valid1, valid4;
  logic        ready1, ready4;
  logic        rv1, rv4;
  logic [63:0] rd1, rd4;
  logic        err1, err4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_LOG2(12), .BASE(64'h8000_0000), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(err1));

  dmem_responder #(.DEPTH_LOG2(12), .BASE(64'h8000_0000), .LATENCY(4)) u4 (
    .clock(clock), .reset(reset), .req_valid(valid4), .req_ready(ready4),
    .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_ready(resp_ready), .resp_rdata(rd4), .resp_err(err4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance (0 = LATENCY 1, 1 = LATENCY 4).
  task automatic xact(input bit sel, input bit wr, input logic [1:0] sz,
                      input logic [63:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat);
    int n;
    rd  = '0;
    er  = 1'b1;
    lat = 0;
    @(negedge clock);
    req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    if (sel) valid4 = 1'b1; else valid1 = 1'b1;
    n = 0;
    while (!(sel ? ready4 : ready1) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("accept_to", {63'd0, n < 20}, 64'd1);
    if (n >= 20) begin
      valid1 = 1'b0; valid4 = 1'b0;
      return;
    end
    @(posedge clock);
    #1 valid1 = 1'b0; valid4 = 1'b0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(sel ? rv4 : rv1) && lat < 40);
    check("resp_to", {63'd0, (sel ? rv4 : rv1)}, 64'd1);
    if (!(sel ? rv4 : rv1)) return;
    rd = sel ? rd4 : rd1;
    er = sel ? err4 : err1;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input bit sel, input bit wr, input logic [1:0] sz,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [63:0] rd;
    logic        er;
    int          lat;
    xact(sel, wr, sz, addr, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {63'd0, er}, {63'd0, exp_er});
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int n;
    reset = 1'b0; resp_ready = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
    req_wr = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready1", {63'd0, ready1}, 64'd0);
    check("rst_valid1", {63'd0, rv1}, 64'd0);
    check("rst_rdata4", rd4, 64'd0);
    check("rst_err4", {63'd0, err4}, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rel_ready1", {63'd0, ready1}, 64'd1);
    check("rel_ready4", {63'd0, ready4}, 64'd1);

    // LATENCY=1: basic store/load and partial-lane stores
    expect_resp("st_d", 0, 1, 2'b11, 64'h8000_0000, 64'h1122334455667788, 64'h1122334455667788, 0, 1);
    expect_resp("ld_d", 0, 0, 2'b11, 64'h8000_0000, 64'h0, 64'h1122334455667788, 0, 1);
    expect_resp("st_b", 0, 1, 2'b00, 64'h8000_0005, 64'hAB, 64'h1122AB4455667788, 0, 1);
    expect_resp("st_h", 0, 1, 2'b01, 64'h8000_0002, 64'hCDEF, 64'h1122AB44CDEF7788, 0, 1);

    // Misaligned and out-of-range accesses
    expect_resp("st_w_mis", 0, 1, 2'b10, 64'h8000_0002, 64'hFFFF_FFFF, 64'h0, 1, 1);
    expect_resp("ld_h_mis", 0, 0, 2'b01, 64'h8000_0001, 64'h0, 64'h0, 1, 1);
    expect_resp("ld_below", 0, 0, 2'b11, 64'h7FFF_FFF8, 64'h0, 64'h0, 1, 1);
    expect_resp("ld_above", 0, 0, 2'b11, 64'h8000_8000, 64'h0, 64'h0, 1, 1);
    expect_resp("st_above", 0, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5, 64'h0, 1, 1);
    expect_resp("ld_unchg", 0, 0, 2'b11, 64'h8000_0000, 64'h0, 64'h1122AB44CDEF7788, 0, 1);

    // Last doubleword in range, aligned word store in the upper half, byte load
    expect_resp("st_last", 0, 1, 2'b11, 64'h8000_7FF8, 64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1);
    expect_resp("ld_last", 0, 0, 2'b11, 64'h8000_7FF8, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1);
    expect_resp("st_w_hi", 0, 1, 2'b10, 64'h8000_0004, 64'hFFFF_FFFF_DEAD_BEEF, 64'hDEADBEEF_CDEF7788, 0, 1);
    expect_resp("ld_b7", 0, 0, 2'b00, 64'h8000_0007, 64'h0, 64'hDEADBEEF_CDEF7788, 0, 1);

    // LATENCY=4 with a stalled response and requests presented while busy
    expect_resp("l4_st", 1, 1, 2'b11, 64'h8000_0100, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 4);
    @(negedge clock);
    req_wr = 1'b0; req_size = 2'b11; req_addr = 64'h8000_0100; valid4 = 1'b1;
    @(posedge clock);
    #1 valid4 = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!rv4) check("l4_ready_busy", {63'd0, ready4}, 64'd0);
    end while (!rv4 && n < 40);
    check("l4_stall_lat", 64'(n), 64'd4);
    req_wr = 1'b1; req_wdata = 64'h0; valid4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("l4_stall_valid", {63'd0, rv4}, 64'd1);
      check("l4_stall_rdata", rd4, 64'h0123_4567_89AB_CDEF);
      check("l4_stall_ready", {63'd0, ready4}, 64'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0; valid4 = 1'b0;
    @(negedge clock);
    check("l4_post_ready", {63'd0, ready4}, 64'd1);
    check("l4_post_valid", {63'd0, rv4}, 64'd0);
    expect_resp("l4_ignored", 1, 0, 2'b11, 64'h8000_0100, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 4);

    // Reset while in WAIT after an accepted store
    @(negedge clock);
    req_wr = 1'b1; req_size = 2'b11; req_addr = 64'h8000_0200; req_wdata = 64'hFEDC_BA98_7654_3210;
    valid4 = 1'b1;
    @(posedge clock);
    #1 valid4 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("wrst_valid", {63'd0, rv4}, 64'd0);
    check("wrst_ready", {63'd0, ready4}, 64'd0);
    check("wrst_rdata", rd4, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("wrst_idle", {63'd0, ready4}, 64'd1);
    @(negedge clock);
    check("wrst_no_resp", {63'd0, rv4}, 64'd0);
    expect_resp("wrst_ld", 1, 0, 2'b11, 64'h8000_0200, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: ysyx_22040931_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving a storage array of 2^DEPTH_LOG2 64-bit doublewords.
REQ-002 SHALL have parameter BASE, default 64'h8000_0000, the byte address of doubleword 0.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..15, the number of cycles from request acceptance to resp_valid.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-006 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 SHALL have port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = double (same encoding as the core memop).
REQ-010 SHALL have port req_addr, input, 64 bits: the byte address.
REQ-011 SHALL have port req_wdata, input, 64 bits: the store data, right-justified (LSB-aligned).
REQ-012 SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-013 SHALL have port resp_ready, input, 1 bit: the requester accepts the response.
REQ-014 SHALL have port resp_rdata, output, 64 bits: the full aligned doubleword containing req_addr (the core extracts lanes and sign-extends).
REQ-015 SHALL have port resp_err, output, 1 bit: the access was out of range or misaligned.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready is 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid & req_ready; at most one transaction is outstanding.
REQ-018 SHALL, on acceptance, move to RESP if LATENCY==1; otherwise it moves to WAIT with the counter loaded to LATENCY-2.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and move to RESP the cycle after the counter reaches 0, so resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL, in RESP, hold resp_valid, resp_rdata and resp_err stable until resp_valid & resp_ready at a rising edge, then return to IDLE.
REQ-021 SHALL not accept a new request in the same cycle as a response handshake; the minimum issue interval is LATENCY+1 cycles.
REQ-022 SHALL compute the index as (req_addr-BASE)>>3 and the in-range condition as BASE <= req_addr < BASE + 8*2^DEPTH_LOG2, with 64-bit unsigned arithmetic and no wrap-around.
REQ-023 SHALL treat an access as misaligned when: half and addr[0]!=0; word and addr[1:0]!=0; double and addr[2:0]!=0.
REQ-024 SHALL compute the byte mask, with o=addr[2:0], as: byte 8'h01<<o; half 8'h03<<o; word 8'h0F<<o; double 8'hFF.
REQ-025 SHALL, for a store, place the lane data as req_wdata<<(8*o) and write only the masked bytes.
REQ-026 SHALL commit a legal store at the acceptance edge and respond with resp_err=0 and resp_rdata = the doubleword after the write.
REQ-027 SHALL, for a load, capture the doubleword at the acceptance edge, so a load issued after a store's response sees the stored data.
REQ-028 SHALL, for an out-of-range or misaligned access, perform no write, respond with resp_err=1 and resp_rdata=0, and keep the latency unchanged.
REQ-029 SHALL ignore req_* inputs while not in IDLE.
REQ-030 SHALL clamp LATENCY values outside 1..15 to the nearest legal value.

Reset
REQ-031 SHALL, while reset==0 at a rising edge, set the state to IDLE, the counter to 0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0.
REQ-032 SHALL drive req_ready=1 from the first edge with reset==1.
REQ-033 SHALL, on reset mid-transaction, drop any pending response; an already-committed store remains in memory.
REQ-034 SHALL not clear storage contents on reset.

Verification
REQ-035 SHALL cover: LATENCY=1, store double 64'h1122334455667788 to 8000_0000, then load 8000_0000 -> each resp_valid 1 cycle after acceptance, load rdata=64'h1122334455667788, err=0.
REQ-036 SHALL cover: store byte 8'hAB to 8000_0005 over the above data -> rdata=64'h1122AB4455667788; then store half 16'hCDEF to 8000_0002 -> 64'h1122AB44CDEF7788.
REQ-037 SHALL cover: store word to 8000_0002, load half from 8000_0001, and load from 7FFF_FFF8 and from BASE+8*4096 -> resp_err=1, rdata=0, memory unchanged.
REQ-038 SHALL cover: LATENCY=4, resp_ready held 0 for 3 cycles -> resp_valid rises 4 cycles after acceptance, data stable while stalled, req_ready=0 until the handshake.
REQ-039 SHALL cover: reset=0 during WAIT after an accepted store -> resp_valid=0, state IDLE, and a following load returns the stored value.
